bcd_updown_counter_nd: RTL and testbench
========================================

// Module: bcd_updown_counter_nd
//
// PURPOSE
//   Parametrised N-digit BCD up/down counter with pause, parallel load, programmable
//   wrap limit, prescaled step rate and per-digit seven-segment drive. Generalises the
//   fixed 00-99-00 two-digit counter to any digit count and modulus. Sits between the
//   board clock domain and the display/LED pins; also exports a binary mirror of the value.
//
// PARAMETERS
//   DIGITS          2   number of BCD digits (1..6); value range 0 .. 10**DIGITS-1
//   DIV             1   clk cycles per count step (1 = step every enabled cycle)
//   SEG_ACTIVE_LOW  1   1: segment bit 0 = lit (common anode); 0: 1 = lit
//   CW              derived = $clog2(10**DIGITS), width of binary mirror
//
// PORTS
//   clk       in   1           system clock, all state on rising edge
//   rst       in   1           synchronous, active-high reset
//   ud        in   1           direction: 1 = up, 0 = down
//   pause     in   1           1 = hold value and prescaler
//   load      in   1           1 = load load_val this cycle
//   load_val  in   4*DIGITS    BCD load value, digit 0 in [3:0]
//   max_val   in   4*DIGITS    BCD wrap limit (terminal value when counting up)
//   bcd       out  4*DIGITS    current value, BCD, digit 0 = ones
//   seg       out  7*DIGITS    seven-seg per digit, {g,f,e,d,c,b,a}, digit 0 in [6:0]
//   count     out  CW          binary equivalent of bcd, updated same edge
//   tc        out  1           one-cycle pulse: wrap occurred on this edge
//
// BEHAVIOUR
//   - Reset: bcd=0, count=0, tc=0, prescaler=0; seg shows "0" on all digits
//     (7'b1000000 per digit when SEG_ACTIVE_LOW=1).
//   - Priority per edge: rst > load > step > hold.
//   - Step enable: prescaler counts 0..DIV-1 while pause=0; step fires on edge where
//     prescaler==DIV-1 (every cycle if DIV=1), prescaler then returns to 0.
//     pause=1 freezes prescaler and value; no step, tc=0.
//   - Up step: if value >= max_val -> value=0, tc=1; else value+1 with BCD carry
//     (digit 9 -> 0, carry into next digit).
//   - Down step: if value==0 -> value=max_val, tc=1; else value-1 with BCD borrow
//     (digit 0 -> 9). If value > max_val on a down step, value-1 (no clamp).
//   - Load: digits >9 in load_val clamp to 9; result > max_val clamps to max_val.
//     Load resets prescaler to 0; tc=0. Load with pause=1 still loads.
//   - ud sampled only on the step edge; direction change takes effect next step.
//   - max_val changed below current value: next up step wraps to 0 with tc=1.
//   - max_val digits >9: treated as 9. max_val=0: up and down both hold 0, tc=1 each step.
//   - Latency: bcd/count/tc registered (1 edge after step condition); seg is a
//     combinational decode of registered bcd (no extra latency). BCD digits 10-15
//     are unreachable; decoder drives all segments off for them.
//   - count maintained as parallel binary register (+1/-1/0/max/load conversion),
//     never re-derived combinationally from bcd.
//
// STRUCTURE
//   - Shared package: SEG_* digit patterns 0-9 (active-high), BCD_NINE, direction
//     constants UD_UP/UD_DOWN.
//   - Sub-module bcd_seg7_dec: 4-bit BCD -> 7-bit segments, polarity parameter;
//     instantiated DIGITS times in a generate loop.
//   - Digit chain carry/borrow and prescaler in this module.
//
// TESTING
//   1 DIGITS=2,DIV=1,max=99: rst 3 cyc, ud=1 100 cyc -> bcd 00..99, wraps 99->00 with
//     tc=1 one cycle, count tracks 0..99.
//   2 ud=0 from 00 -> next bcd=99 (max), tc=1; then 98, 97; seg digit0 = 7'b0000000 for 8.
//   3 pause=1 for 30 cyc mid-count at 42 -> bcd holds 42; release -> 43 next step.
//   4 DIV=4: after rst with ud=1, first change at edge 4 (bcd=01), then every 4 cycles.
//   5 max=59, load_val=0x75 -> bcd=59; load 0xA3 -> 93 clamped to 59; up -> 00, tc=1.
//   6 rst asserted mid-count at 37 with load=1 same cycle -> bcd=00, count=0, tc=0.

Source files
------------

// File: rtl/bcd_updown_counter_nd_pkg.sv
// Shared constants for the N-digit BCD up/down counter:
// active-high seven-segment patterns, BCD limit and direction codes.
package bcd_updown_counter_nd_pkg;

  // Segment order {g,f,e,d,c,b,a}, 1 = lit
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;

  localparam logic [3:0] BCD_NINE = 4'd9;

  localparam logic UD_UP   = 1'b1;
  localparam logic UD_DOWN = 1'b0;

endpackage

// File: rtl/bcd_updown_counter_nd_seg7_dec.sv
// One-digit BCD to seven-segment decoder with selectable polarity.
// Ports: digit (4-bit BCD in), seg ({g,f,e,d,c,b,a} out); codes 10-15 blank.
module bcd_seg7_dec
  import bcd_updown_counter_nd_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  logic [6:0] lit;

  always_comb begin
    lit = '0;
    unique case (digit)
      4'd0:    lit = SEG_0;
      4'd1:    lit = SEG_1;
      4'd2:    lit = SEG_2;
      4'd3:    lit = SEG_3;
      4'd4:    lit = SEG_4;
      4'd5:    lit = SEG_5;
      4'd6:    lit = SEG_6;
      4'd7:    lit = SEG_7;
      4'd8:    lit = SEG_8;
      4'd9:    lit = SEG_9;
      default: lit = '0;
    endcase
  end

  assign seg = (ACTIVE_LOW != 0) ? ~lit : lit;

endmodule

// File: rtl/bcd_updown_counter_nd.sv
// N-digit BCD up/down counter: pause, clamped load, wrap limit, prescaler.
// Ports: clk, rst, ud, pause, load, load_val, max_val -> bcd, seg, count, tc.
module bcd_updown_counter_nd
  import bcd_updown_counter_nd_pkg::*;
#(
  parameter int DIGITS         = 2,
  parameter int DIV            = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  localparam int CW            = $clog2(10**DIGITS),
  localparam int BW            = 4*DIGITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ud,
  input  logic              pause,
  input  logic              load,
  input  logic [BW-1:0]     load_val,
  input  logic [BW-1:0]     max_val,
  output logic [BW-1:0]     bcd,
  output logic [7*DIGITS-1:0] seg,
  output logic [CW-1:0]     count,
  output logic              tc
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(DIV-1);

  function automatic logic [BW-1:0] clamp9(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++)
      if (r[4*i+:4] > BCD_NINE) r[4*i+:4] = BCD_NINE;
    return r;
  endfunction

  function automatic logic [CW-1:0] to_bin(input logic [BW-1:0] v);
    int acc;
    acc = 0;
    for (int i = DIGITS-1; i >= 0; i--)
      acc = acc*10 + int'(v[4*i+:4]);
    return CW'(acc);
  endfunction

  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (c) begin
        if (r[4*i+:4] == BCD_NINE) r[4*i+:4] = 4'd0;
        else begin
          r[4*i+:4] = r[4*i+:4] + 4'd1;
          c = 1'b0;
        end
      end
    return r;
  endfunction

  function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (b) begin
        if (r[4*i+:4] == 4'd0) r[4*i+:4] = BCD_NINE;
        else begin
          r[4*i+:4] = r[4*i+:4] - 4'd1;
          b = 1'b0;
        end
      end
    return r;
  endfunction

  logic [BW-1:0] bcd_q, bcd_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          tc_q, tc_n;
  logic [PW-1:0] psc_q, psc_n;
  logic          step;

  logic [BW-1:0] max_c, ld_c, ld_v;
  logic [CW-1:0] max_b, ld_b;

  // Limit and load value are sanitised once; valid BCD compares as binary.
  assign max_c = clamp9(max_val);
  assign ld_c  = clamp9(load_val);
  assign ld_v  = (ld_c > max_c) ? max_c : ld_c;
  assign max_b = to_bin(max_c);
  assign ld_b  = to_bin(ld_v);

  assign step = !pause && (psc_q == PSC_LAST);

  always_comb begin
    bcd_n = bcd_q;
    cnt_n = cnt_q;
    tc_n  = 1'b0;
    psc_n = psc_q;
    if (load) begin
      bcd_n = ld_v;
      cnt_n = ld_b;
      psc_n = '0;
    end else if (step) begin
      psc_n = '0;
      if (ud == UD_UP) begin
        if (bcd_q >= max_c) begin
          bcd_n = '0;
          cnt_n = '0;
          tc_n  = 1'b1;
        end else begin
          bcd_n = bcd_inc(bcd_q);
          cnt_n = cnt_q + CW'(1);
        end
      end else begin
        if (bcd_q == '0) begin
          bcd_n = max_c;
          cnt_n = max_b;
          tc_n  = 1'b1;
        end else begin
          bcd_n = bcd_dec(bcd_q);
          cnt_n = cnt_q - CW'(1);
        end
      end
    end else if (!pause) begin
      psc_n = psc_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q <= '0;
      cnt_q <= '0;
      tc_q  <= 1'b0;
      psc_q <= '0;
    end else begin
      bcd_q <= bcd_n;
      cnt_q <= cnt_n;
      tc_q  <= tc_n;
      psc_q <= psc_n;
    end
  end

  assign bcd   = bcd_q;
  assign count = cnt_q;
  assign tc    = tc_q;

  for (genvar i = 0; i < DIGITS; i++) begin : g_seg
    bcd_seg7_dec #(
      .ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_dec (
      .digit(bcd_q[4*i+:4]),
      .seg  (seg[7*i+:7])
    );
  end

endmodule

// File: tb/tb_bcd_updown_counter_nd.sv
// Directed self-checking bench for bcd_updown_counter_nd.
// Two instances: DIV=1 (main) and DIV=4 (prescaler).
module tb_bcd_updown_counter_nd;

  logic        clk;
  logic        rst, rst_b;
  logic        ud, pause, load;
  logic [7:0]  load_val, max_val;

  logic [7:0]  bcd, bcd_b;
  logic [13:0] seg, seg_b;
  logic [6:0]  count, count_b;
  logic        tc, tc_b;

  int errors = 0;
  int checks = 0;

  bcd_updown_counter_nd #(
    .DIGITS(2), .DIV(1), .SEG_ACTIVE_LOW(1)
  ) u_dut (
    .clk(clk), .rst(rst), .ud(ud), .pause(pause),
    .load(load), .load_val(load_val), .max_val(max_val),
    .bcd(bcd), .seg(seg), .count(count), .tc(tc)
  );

  bcd_updown_counter_nd #(
    .DIGITS(2), .DIV(4), .SEG_ACTIVE_LOW(1)
  ) u_div4 (
    .clk(clk), .rst(rst_b), .ud(ud), .pause(pause),
    .load(load), .load_val(load_val), .max_val(max_val),
    .bcd(bcd_b), .seg(seg_b), .count(count_b), .tc(tc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; rst_b = 1; ud = 1; pause = 0; load = 0;
    load_val = 8'h00; max_val = 8'h99;
    repeat (3) tick();
    checks++;
    if (bcd !== 8'h00 || count !== 7'd0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL reset: bcd=%h count=%0d tc=%b want 00/0/0", bcd, count, tc);
    end
    checks++;
    if (seg !== {7'b1000000, 7'b1000000}) begin
      errors++;
      $display("FAIL reset_seg: seg=%b want 10000001000000", seg);
    end
    rst = 0;
  endtask

  task automatic test_count_up;
    for (int i = 1; i <= 100; i++) begin
      tick();
      checks++;
      if (bcd !== to_bcd(i % 100) || count !== 7'(i % 100)) begin
        errors++;
        $display("FAIL up_%0d: bcd=%h count=%0d want %h/%0d",
                 i, bcd, count, to_bcd(i % 100), i % 100);
      end
      checks++;
      if (tc !== (i == 100)) begin
        errors++;
        $display("FAIL up_tc_%0d: tc=%b want %b", i, tc, i == 100);
      end
    end
  endtask

  task automatic test_count_down;
    ud = 0;
    tick();
    checks++;
    if (bcd !== 8'h99 || count !== 7'd99 || tc !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap: bcd=%h count=%0d tc=%b want 99/99/1", bcd, count, tc);
    end
    tick();
    checks++;
    if (bcd !== 8'h98 || count !== 7'd98 || tc !== 1'b0) begin
      errors++;
      $display("FAIL down_98: bcd=%h count=%0d tc=%b want 98/98/0", bcd, count, tc);
    end
    checks++;
    if (seg[6:0] !== 7'b0000000) begin
      errors++;
      $display("FAIL seg_8: seg0=%b want 0000000", seg[6:0]);
    end
    tick();
    checks++;
    if (bcd !== 8'h97 || count !== 7'd97) begin
      errors++;
      $display("FAIL down_97: bcd=%h count=%0d want 97/97", bcd, count);
    end
  endtask

  task automatic test_pause;
    load = 1; load_val = 8'h42;
    tick();
    load = 0; pause = 1; ud = 1;
    repeat (30) tick();
    checks++;
    if (bcd !== 8'h42 || count !== 7'd42 || tc !== 1'b0) begin
      errors++;
      $display("FAIL pause_hold: bcd=%h count=%0d tc=%b want 42/42/0", bcd, count, tc);
    end
    checks++;
    if (seg !== {7'b0011001, 7'b0100100}) begin
      errors++;
      $display("FAIL seg_42: seg=%b want 00110010100100", seg);
    end
    pause = 0;
    tick();
    checks++;
    if (bcd !== 8'h43 || count !== 7'd43) begin
      errors++;
      $display("FAIL pause_release: bcd=%h count=%0d want 43/43", bcd, count);
    end
  endtask

  task automatic test_div4;
    max_val = 8'h99; ud = 1; pause = 0; load = 0;
    rst_b = 1;
    tick();
    rst_b = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (bcd_b !== to_bcd(i / 4) || count_b !== 7'(i / 4) || tc_b !== 1'b0) begin
        errors++;
        $display("FAIL div4_edge%0d: bcd=%h count=%0d tc=%b want %h/%0d/0",
                 i, bcd_b, count_b, tc_b, to_bcd(i / 4), i / 4);
      end
    end
    checks++;
    if (seg_b !== {7'b1000000, 7'b0100100}) begin
      errors++;
      $display("FAIL div4_seg: seg=%b want 10000000100100", seg_b);
    end
  endtask

  task automatic test_load_clamp;
    max_val = 8'h59; load = 1; load_val = 8'h75;
    tick();
    checks++;
    if (bcd !== 8'h59 || count !== 7'd59 || tc !== 1'b0) begin
      errors++;
      $display("FAIL load_75: bcd=%h count=%0d tc=%b want 59/59/0", bcd, count, tc);
    end
    load_val = 8'h3A;
    tick();
    checks++;
    if (bcd !== 8'h39 || count !== 7'd39) begin
      errors++;
      $display("FAIL load_3A: bcd=%h count=%0d want 39/39", bcd, count);
    end
    load_val = 8'hA3;
    tick();
    checks++;
    if (bcd !== 8'h59 || count !== 7'd59) begin
      errors++;
      $display("FAIL load_A3: bcd=%h count=%0d want 59/59", bcd, count);
    end
    load = 0; ud = 1;
    tick();
    checks++;
    if (bcd !== 8'h00 || count !== 7'd0 || tc !== 1'b1) begin
      errors++;
      $display("FAIL max59_wrap: bcd=%h count=%0d tc=%b want 00/0/1", bcd, count, tc);
    end
  endtask

  task automatic test_max_zero;
    max_val = 8'h00; ud = 1;
    tick();
    checks++;
    if (bcd !== 8'h00 || tc !== 1'b1) begin
      errors++;
      $display("FAIL max0_up: bcd=%h tc=%b want 00/1", bcd, tc);
    end
    ud = 0;
    tick();
    checks++;
    if (bcd !== 8'h00 || count !== 7'd0 || tc !== 1'b1) begin
      errors++;
      $display("FAIL max0_down: bcd=%h count=%0d tc=%b want 00/0/1", bcd, count, tc);
    end
  endtask

  task automatic test_max_lowered;
    max_val = 8'h99; load = 1; load_val = 8'h50;
    tick();
    load = 0; max_val = 8'h20; ud = 1;
    tick();
    checks++;
    if (bcd !== 8'h00 || count !== 7'd0 || tc !== 1'b1) begin
      errors++;
      $display("FAIL max_lowered: bcd=%h count=%0d tc=%b want 00/0/1", bcd, count, tc);
    end
    max_val = 8'h9F; ud = 0;
    tick();
    checks++;
    if (bcd !== 8'h99 || count !== 7'd99 || tc !== 1'b1) begin
      errors++;
      $display("FAIL max_9F_down: bcd=%h count=%0d tc=%b want 99/99/1", bcd, count, tc);
    end
  endtask

  task automatic test_reset_over_load;
    max_val = 8'h99; load = 1; load_val = 8'h37; ud = 1;
    tick();
    checks++;
    if (bcd !== 8'h37 || count !== 7'd37) begin
      errors++;
      $display("FAIL load_37: bcd=%h count=%0d want 37/37", bcd, count);
    end
    rst = 1; load_val = 8'h55;
    tick();
    checks++;
    if (bcd !== 8'h00 || count !== 7'd0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL rst_over_load: bcd=%h count=%0d tc=%b want 00/0/0", bcd, count, tc);
    end
    rst = 0; load = 0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_pause();
    test_div4();
    test_load_clamp();
    test_max_zero();
    test_max_lowered();
    test_reset_over_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
